// File: rtl/absolute_difference_calculator.sv
`default_nettype none
// ============================================================================
// Module  : absolute_difference_calculator
// Purpose : Registered |A - B| with compare flags and a clearable running max.
// Revision: 1.0 - initial release
// ============================================================================
module absolute_difference_calculator #(
  parameter int WIDTH = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             clear_max,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             out_valid,
  output logic [WIDTH-1:0] result,
  output logic             a_gt_b,
  output logic             a_eq_b,
  output logic [WIDTH-1:0] max_result
);

  logic [WIDTH:0]   w_diff;
  logic             w_borrow;
  logic [WIDTH-1:0] w_abs;
  logic [WIDTH-1:0] w_max_base;

  logic             out_valid_d, out_valid_q;
  logic [WIDTH-1:0] result_d, result_q;
  logic             a_gt_b_d, a_gt_b_q;
  logic             a_eq_b_d, a_eq_b_q;
  logic [WIDTH-1:0] max_result_d, max_result_q;

  // One extra bit on the subtraction exposes the borrow; negating the
  // truncated difference yields B - A without a second subtractor.
  always_comb begin
    w_diff     = {1'b0, A} - {1'b0, B};
    w_borrow   = w_diff[WIDTH];
    w_abs      = w_borrow ? (~w_diff[WIDTH-1:0] + WIDTH'(1)) : w_diff[WIDTH-1:0];
    w_max_base = clear_max ? '0 : max_result_q;
  end

  always_comb begin
    out_valid_d  = in_valid;
    result_d     = result_q;
    a_gt_b_d     = a_gt_b_q;
    a_eq_b_d     = a_eq_b_q;
    max_result_d = w_max_base;
    if (in_valid) begin
      result_d = w_abs;
      a_gt_b_d = ~w_borrow & (w_diff != '0);
      a_eq_b_d = (w_diff == '0);
      // Clear is folded in first so a simultaneous pair seeds the new max.
      if (w_abs > w_max_base) begin
        max_result_d = w_abs;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      result_q     <= '0;
      a_gt_b_q     <= 1'b0;
      a_eq_b_q     <= 1'b0;
      max_result_q <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      result_q     <= result_d;
      a_gt_b_q     <= a_gt_b_d;
      a_eq_b_q     <= a_eq_b_d;
      max_result_q <= max_result_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign result     = result_q;
  assign a_gt_b     = a_gt_b_q;
  assign a_eq_b     = a_eq_b_q;
  assign max_result = max_result_q;

endmodule
`default_nettype wire

// File: tb/tb_absolute_difference_calculator.sv
`default_nettype none
// ============================================================================
// Module  : tb_absolute_difference_calculator
// Purpose : Bench for absolute_difference_calculator at WIDTH 5 and WIDTH 8.
// Revision: 1.0 - initial release
// ============================================================================
module tb_absolute_difference_calculator;

  logic clk = 1'b0;
  logic rst = 1'b0;

  logic       v5 = 1'b0, c5 = 1'b0;
  logic [4:0] a5 = '0, b5 = '0;
  logic       ov5, gt5, eq5;
  logic [4:0] r5, mx5;

  logic       v8 = 1'b0, c8 = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       ov8, gt8, eq8;
  logic [7:0] r8, mx8;

  int n_checks = 0;
  int n_errors = 0;

  // Reference state: plain integers, updated from the rules of the block.
  int m5_ov = 0, m5_res = 0, m5_gt = 0, m5_eq = 0, m5_max = 0;
  int m8_ov = 0, m8_res = 0, m8_gt = 0, m8_eq = 0, m8_max = 0;

  absolute_difference_calculator #(.WIDTH(5)) u5 (
    .clk(clk), .rst(rst), .in_valid(v5), .clear_max(c5), .A(a5), .B(b5),
    .out_valid(ov5), .result(r5), .a_gt_b(gt5), .a_eq_b(eq5), .max_result(mx5)
  );

  absolute_difference_calculator #(.WIDTH(8)) u8 (
    .clk(clk), .rst(rst), .in_valid(v8), .clear_max(c8), .A(a8), .B(b8),
    .out_valid(ov8), .result(r8), .a_gt_b(gt8), .a_eq_b(eq8), .max_result(mx8)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(posedge rst) begin
    m5_ov = 0; m5_res = 0; m5_gt = 0; m5_eq = 0; m5_max = 0;
    m8_ov = 0; m8_res = 0; m8_gt = 0; m8_eq = 0; m8_max = 0;
  end

  // Model update on each edge, then compare every output 1 time unit later.
  initial begin
    int ia, ib, base;
    forever begin
      @(posedge clk);
      if (!rst) begin
        ia = int'(a5); ib = int'(b5);
        base = c5 ? 0 : m5_max;
        m5_ov = int'(v5);
        if (v5) begin
          m5_res = (ia > ib) ? ia - ib : ib - ia;
          m5_gt  = int'(ia > ib);
          m5_eq  = int'(ia == ib);
          base   = (m5_res > base) ? m5_res : base;
        end
        m5_max = base;

        ia = int'(a8); ib = int'(b8);
        base = c8 ? 0 : m8_max;
        m8_ov = int'(v8);
        if (v8) begin
          m8_res = (ia > ib) ? ia - ib : ib - ia;
          m8_gt  = int'(ia > ib);
          m8_eq  = int'(ia == ib);
          base   = (m8_res > base) ? m8_res : base;
        end
        m8_max = base;
      end
      #1;
      check("w5_out_valid", int'(ov5), m5_ov);
      check("w5_result",    int'(r5),  m5_res);
      check("w5_a_gt_b",    int'(gt5), m5_gt);
      check("w5_a_eq_b",    int'(eq5), m5_eq);
      check("w5_max",       int'(mx5), m5_max);
      check("w8_out_valid", int'(ov8), m8_ov);
      check("w8_result",    int'(r8),  m8_res);
      check("w8_a_gt_b",    int'(gt8), m8_gt);
      check("w8_a_eq_b",    int'(eq8), m8_eq);
      check("w8_max",       int'(mx8), m8_max);
    end
  end

  // Drive one 5-bit cycle at the falling edge; return 2 units after the
  // following rising edge so registered outputs can be checked literally.
  task automatic apply5(input int a, input int b, input logic v, input logic c);
    @(negedge clk);
    a5 = 5'(a); b5 = 5'(b); v5 = v; c5 = c;
    @(posedge clk);
    #2;
  endtask

  initial begin
    int d;
    #1 rst = 1'b1;
    #1;
    check("reset_out_valid", int'(ov5), 0);
    check("reset_result",    int'(r5),  0);
    check("reset_max",       int'(mx5), 0);
    repeat (2) @(posedge clk);
    @(negedge clk) rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        apply5(i, j, 1'b1, 1'b0);
        d = (i > j) ? i - j : j - i;
        check("sweep_result", int'(r5), d);
        check("sweep_valid", int'(ov5), 1);
      end
    end

    apply5(3, 1, 1'b1, 1'b0);
    check("a3b1_result", int'(r5), 2);
    check("a3b1_gt", int'(gt5), 1);
    apply5(1, 3, 1'b1, 1'b0);
    check("a1b3_result", int'(r5), 2);
    check("a1b3_gt", int'(gt5), 0);
    check("a1b3_eq", int'(eq5), 0);

    apply5(31, 0, 1'b1, 1'b0);
    check("a31b0_result", int'(r5), 31);
    apply5(0, 31, 1'b1, 1'b0);
    check("a0b31_result", int'(r5), 31);
    apply5(17, 17, 1'b1, 1'b0);
    check("a17b17_result", int'(r5), 0);
    check("a17b17_eq", int'(eq5), 1);
    check("a17b17_gt", int'(gt5), 0);

    apply5(6, 2, 1'b1, 1'b0);
    check("a6b2_result", int'(r5), 4);
    check("a6b2_valid", int'(ov5), 1);
    apply5(9, 1, 1'b0, 1'b0);
    check("gated_result", int'(r5), 4);
    check("gated_valid", int'(ov5), 0);

    // Max is 31 here; clearing alongside a pair of result 4 restarts at 4.
    apply5(6, 2, 1'b1, 1'b1);
    check("max_seq0", int'(mx5), 4);
    apply5(20, 0, 1'b1, 1'b0);
    check("max_seq1", int'(mx5), 20);
    apply5(0, 7, 1'b1, 1'b0);
    check("max_seq2", int'(mx5), 20);
    apply5(5, 2, 1'b1, 1'b1);
    check("max_clear_pair", int'(mx5), 3);
    check("max_clear_result", int'(r5), 3);

    @(negedge clk);
    a5 = 5'd10; b5 = 5'd3; v5 = 1'b1; c5 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("async_rst_valid", int'(ov5), 0);
    check("async_rst_result", int'(r5), 0);
    check("async_rst_max", int'(mx5), 0);
    @(negedge clk);
    rst = 1'b0; v5 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
      check("post_rst_valid", int'(ov5), 0);
    end

    for (int k = 0; k < 10000; k++) begin
      @(negedge clk);
      a8 = 8'($urandom);
      b8 = 8'($urandom);
      v8 = ($urandom_range(0, 3) != 0);
      c8 = ($urandom_range(0, 15) == 0);
    end
    @(negedge clk);
    v8 = 1'b0; c8 = 1'b0;
    repeat (2) @(posedge clk);
    #3;

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/absolute_difference_calculator.md
# absolute_difference_calculator

Registered unsigned absolute-difference unit: each accepted operand pair (A, B) produces |A − B| one clock later, with magnitude-compare flags and a running maximum of all results since reset or clear. It sits in the datapath as a one-stage pipelined arithmetic block, fed by a valid-qualified producer and read by a downstream consumer that samples on `out_valid`.

## Interface
- `WIDTH`, default 5: operand and result width in bits; legal values are 2 and above.
- `clk`  in  1: single clock; all state updates on its rising edge.
- `rst`  in  1: reset, asynchronous and active-high. Clears all registers.
- `in_valid`  in  1: A and B are valid this cycle and must be accepted.
- `clear_max`  in  1: synchronous clear of `max_result`.
- `A`  in  WIDTH: unsigned operand.
- `B`  in  WIDTH: unsigned operand.
- `out_valid`  out  1: `result` and the flags hold a new value this cycle.
- `result`  out  WIDTH: |A − B| of the last accepted pair.
- `a_gt_b`  out  1: A > B for the last accepted pair.
- `a_eq_b`  out  1: A == B for the last accepted pair.
- `max_result`  out  WIDTH: largest `result` produced since reset or the last `clear_max`.

## Operation
- Operands are unsigned, and no input pair is illegal.
- Compute d = {1'b0,A} − {1'b0,B} in WIDTH+1 bits. Borrow = d[WIDTH].
- If borrow = 0, result = d[WIDTH-1:0]. Otherwise result = B − A, which is the two's-complement negation of d truncated to WIDTH bits.
- The result always fits in WIDTH bits: the maximum is 2^WIDTH − 1, when one operand is 0 and the other is all ones. There is no overflow and no saturation.
- a_gt_b = ~borrow & (d ≠ 0). a_eq_b = (d == 0). At most one of the two flags is set.
- The block accepts the pair on every clock edge where `in_valid` = 1. There is no backpressure, so back-to-back pairs produce back-to-back results.
- When `in_valid` = 0: `result`, `a_gt_b`, `a_eq_b` and `max_result` hold their values, and `out_valid` goes to 0.
- Running maximum: on an accepted pair, `max_result` ← max(`max_result`, new result). The new result is used, not the old registered value.
- `clear_max` = 1 sets `max_result` to 0 on that edge.
- If `clear_max` and `in_valid` are both 1 in the same cycle, `max_result` ← the new result. The clear applies first, then the comparison.

## Timing
- Latency is 1 cycle. A pair sampled at edge N appears on `result`, the flags and `max_result` after edge N. `out_valid` = 1 for exactly that cycle.
- Throughput is one pair per cycle.
- All outputs are registered, with no combinational path from inputs to outputs.
- While `rst` = 1, all outputs are 0: `out_valid` = 0, `result` = 0, `a_gt_b` = 0, `a_eq_b` = 0, `max_result` = 0.
- Reset takes effect immediately, without waiting for a clock edge.
- Reset in the middle of operation discards any pair sampled in the same cycle. No `out_valid` pulse follows reset deassertion unless a new pair is accepted.
- The first acceptance happens on the first rising edge after `rst` deasserts, provided `in_valid` = 1 on that edge.

## Test plan
- Exhaustive sweep with WIDTH=5, A and B each over 0..3, one pair per cycle. Each cycle must give `result` = |i − j| with `out_valid` = 1. Also check the flags: for example A=3, B=1 → result 2, a_gt_b=1; A=1, B=3 → result 2, a_gt_b=0, a_eq_b=0.
- Width extremes: A=31, B=0 → 31. A=0, B=31 → 31. A=17, B=17 → 0 with a_eq_b=1. A=6, B=2 → 4.
- Valid gating: apply A=6, B=2 with in_valid=1, then A=9, B=1 with in_valid=0. The output must stay at 4 and `out_valid` must go 1 then 0.
- Running max: feed results 4, 20, 7 in sequence. `max_result` must read 4, 20, 20. Then apply `clear_max` together with a pair whose result is 3; `max_result` must read 3.
- Reset: assert `rst` asynchronously mid-stream, between edges, while in_valid=1. All outputs must go to 0 immediately. After deassertion with in_valid=0, `out_valid` must stay 0.
- Random regression: WIDTH=8, 10,000 random pairs with random `in_valid`, compared against a reference model. Check `result`, both flags, `max_result` and the 1-cycle latency.
